// File: rtl/jtoutrun_roadram.sv
// Double-buffered road RAM and road control register on the OutRun sub-CPU bus.
// The sub CPU writes the back buffer (~bank) and the road renderer scans the
// front buffer (bank). A read of the control location arms a buffer swap that
// takes effect on the next LVBL falling edge.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cpu_addr        sub CPU word address within road RAM
//   cpu_dout        sub CPU write data
//   dsn             data strobes, active low ([1]=upper byte, [0]=lower byte)
//   rnw             1=read, 0=write
//   ram_cs          road RAM select (level, held until cpu_ok)
//   ctrl_cs         road control register select (level, held until cpu_ok)
//   cpu_din         read data to sub CPU
//   cpu_ok          one-cycle access acknowledge
//   LVBL            vertical blank, active low
//   rd_addr         renderer word address
//   rd_data         renderer data from the front buffer, one-cycle latency
//   road_mode       control register bits [1:0]
//   bank            index of the front buffer
module jtoutrun_roadram #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_dout,
    input  logic [1:0]    dsn,
    input  logic          rnw,
    input  logic          ram_cs,
    input  logic          ctrl_cs,
    output logic [15:0]   cpu_din,
    output logic          cpu_ok,
    input  logic          LVBL,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic [1:0]    road_mode,
    output logic          bank
);

    localparam int unsigned Depth = 1 << AW;

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_t;

    state_t        state_q;
    logic          cs, cs_q, lvbl_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   data_q;
    logic [1:0]    dsn_q;
    logic          rnw_q, ctrl_q;
    logic          bank_q, swap_pend_q;
    logic [1:0]    road_mode_q;
    logic          acc, ctrl_rd_acc, ram_wr_acc, vb_edge;

    logic [15:0] mem0 [Depth];
    logic [15:0] mem1 [Depth];

    assign cs          = ram_cs | ctrl_cs;
    assign acc         = state_q == StAcc;
    assign ctrl_rd_acc = acc & ctrl_q & rnw_q;
    assign ram_wr_acc  = acc & ~ctrl_q & ~rnw_q;
    assign vb_edge     = lvbl_q & ~LVBL;

    assign bank      = bank_q;
    assign road_mode = road_mode_q;

    // cs_q is deliberately not reset: a select still held across reset must
    // not be seen as a fresh rising edge.
    always_ff @(posedge clk) begin
        cs_q   <= cs;
        lvbl_q <= LVBL;
        if (rst) begin
            state_q     <= StIdle;
            cpu_ok      <= 1'b0;
            cpu_din     <= 16'd0;
            bank_q      <= 1'b0;
            swap_pend_q <= 1'b0;
            road_mode_q <= 2'd0;
        end else begin
            cpu_ok <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cs && !cs_q) begin
                        addr_q  <= cpu_addr;
                        data_q  <= cpu_dout;
                        dsn_q   <= dsn;
                        rnw_q   <= rnw;
                        ctrl_q  <= ctrl_cs;
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    cpu_ok  <= 1'b1;
                    state_q <= StDone;
                    if (ctrl_q) begin
                        if (rnw_q) begin
                            cpu_din <= {14'd0, road_mode_q};
                        end else if (!dsn_q[0]) begin
                            road_mode_q <= data_q[1:0];
                        end
                    end else if (rnw_q) begin
                        // Back buffer is the one not on display
                        cpu_din <= bank_q ? mem0[addr_q] : mem1[addr_q];
                    end
                end
                StDone: begin
                    if (!cs) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // A control read landing on the blank edge itself still swaps now
            if (vb_edge && (swap_pend_q || ctrl_rd_acc)) begin
                bank_q      <= ~bank_q;
                swap_pend_q <= 1'b0;
            end else if (ctrl_rd_acc) begin
                swap_pend_q <= 1'b1;
            end
        end
    end

    // CPU write port: buffer 0 is the back buffer while bank=1
    always_ff @(posedge clk) begin
        if (!rst && ram_wr_acc && bank_q) begin
            if (!dsn_q[1]) mem0[addr_q][15:8] <= data_q[15:8];
            if (!dsn_q[0]) mem0[addr_q][7:0]  <= data_q[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ram_wr_acc && !bank_q) begin
            if (!dsn_q[1]) mem1[addr_q][15:8] <= data_q[15:8];
            if (!dsn_q[0]) mem1[addr_q][7:0]  <= data_q[7:0];
        end
    end

    // Renderer port reads the front buffer, independent of CPU activity
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 16'd0;
        end else begin
            rd_data <= bank_q ? mem1[rd_addr] : mem0[rd_addr];
        end
    end

endmodule

// File: tb/tb_jtoutrun_roadram.sv
// Self-checking bench for jtoutrun_roadram: directed steps from the test plan
// followed by a randomized phase, all checked against a buffer-level model.
module tb_jtoutrun_roadram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] cpu_addr = '0;
    logic [15:0] cpu_dout = '0;
    logic [1:0]  dsn = 2'b11;
    logic        rnw = 1'b1;
    logic        ram_cs = 1'b0;
    logic        ctrl_cs = 1'b0;
    logic [15:0] cpu_din;
    logic        cpu_ok;
    logic        LVBL = 1'b1;
    logic [10:0] rd_addr = '0;
    logic [15:0] rd_data;
    logic [1:0]  road_mode;
    logic        bank;

    jtoutrun_roadram #(.AW(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .dsn       (dsn),
        .rnw       (rnw),
        .ram_cs    (ram_cs),
        .ctrl_cs   (ctrl_cs),
        .cpu_din   (cpu_din),
        .cpu_ok    (cpu_ok),
        .LVBL      (LVBL),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .road_mode (road_mode),
        .bank      (bank)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: two buffers, which is on display, pending swap, mode bits
    logic [15:0] m_mem   [2][2048];
    bit          m_known [2][2048];
    int          m_bank = 0;
    bit          m_pend = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [10:0] pool [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus access; cpu_ok must rise exactly two cycles after cs rises
    task automatic cpu_acc(input bit ctrl, input bit rd, input logic [10:0] a,
                           input logic [15:0] d, input logic [1:0] ds, input int hold,
                           input bit vb, output logic [15:0] q);
        step();
        cpu_addr = a; cpu_dout = d; dsn = ds; rnw = rd;
        ram_cs = !ctrl; ctrl_cs = ctrl;
        step();
        check("ok_early", 32'(cpu_ok), 32'd0);
        if (vb) LVBL = 1'b0;
        // Scramble the bus to show the request was latched
        cpu_addr = 11'($urandom); cpu_dout = 16'($urandom);
        dsn = 2'($urandom); rnw = 1'($urandom);
        step();
        check("ok_pulse", 32'(cpu_ok), 32'd1);
        q = cpu_din;
        for (int i = 0; i < hold; i++) begin
            step();
            check("ok_held", 32'(cpu_ok), 32'd0);
        end
        ram_cs = 1'b0; ctrl_cs = 1'b0;
        step();
        check("ok_after", 32'(cpu_ok), 32'd0);
        LVBL = 1'b1;
    endtask

    task automatic ram_wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] ds);
        logic [15:0] q;
        int b;
        cpu_acc(1'b0, 1'b0, a, d, ds, 0, 1'b0, q);
        b = 1 - m_bank;
        if (!ds[1]) m_mem[b][a][15:8] = d[15:8];
        if (!ds[0]) m_mem[b][a][7:0]  = d[7:0];
        if (ds == 2'b00) m_known[b][a] = 1'b1;
    endtask

    task automatic ram_rd(input string tag, input logic [10:0] a, input int hold);
        logic [15:0] q;
        int b;
        cpu_acc(1'b0, 1'b1, a, 16'h0, 2'b00, hold, 1'b0, q);
        b = 1 - m_bank;
        if (m_known[b][a]) check(tag, 32'(q), 32'(m_mem[b][a]));
    endtask

    task automatic ctrl_wr(input logic [15:0] d, input logic [1:0] ds);
        logic [15:0] q;
        cpu_acc(1'b1, 1'b0, 11'h0, d, ds, 0, 1'b0, q);
        if (!ds[0]) m_mode = d[1:0];
        check("road_mode", 32'(road_mode), 32'(m_mode));
    endtask

    task automatic ctrl_rd(input bit vb);
        logic [15:0] q;
        cpu_acc(1'b1, 1'b1, 11'h0, 16'h0, 2'b00, 0, vb, q);
        check("ctrl_rd", 32'(q), 32'(m_mode));
        if (vb) begin
            m_bank = 1 - m_bank;
            m_pend = 1'b0;
        end else begin
            m_pend = 1'b1;
        end
        check("bank_ctrl", 32'(bank), 32'(m_bank));
    endtask

    task automatic vblank();
        step();
        LVBL = 1'b0;
        step();
        if (m_pend) begin
            m_bank = 1 - m_bank;
            m_pend = 1'b0;
        end
        check("bank_vb", 32'(bank), 32'(m_bank));
        LVBL = 1'b1;
        step();
    endtask

    task automatic rend(input string tag, input logic [10:0] a);
        step();
        rd_addr = a;
        step();
        if (m_known[m_bank][a]) check(tag, 32'(rd_data), 32'(m_mem[m_bank][a]));
    endtask

    initial begin
        foreach (m_known[i, j]) m_known[i][j] = 1'b0;
        pool[0] = 11'h010; pool[1] = 11'h020; pool[2] = 11'h7FF;
        for (int i = 3; i < 16; i++) pool[i] = 11'($urandom);

        // Reset state
        repeat (3) step();
        check("rst_bank", 32'(bank), 32'd0);
        check("rst_mode", 32'(road_mode), 32'd0);
        check("rst_ok", 32'(cpu_ok), 32'd0);
        check("rst_din", 32'(cpu_din), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        rst = 1'b0;
        step();

        // Fill the pool addresses in both buffers
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) ram_wr(pool[i], 16'($urandom), 2'b00);
            ctrl_rd(1'b0);
            vblank();
        end
        check("bank_init", 32'(bank), 32'd0);

        // Write / read back without swap; held select yields one cpu_ok
        ram_wr(11'h010, 16'hA5C3, 2'b00);
        ram_rd("rd_a5c3", 11'h010, 3);
        check("rd_a5c3_lit", 32'(m_mem[1][11'h010]), 32'h0000A5C3);
        rend("rend_front", 11'h010);

        // Byte masking
        ram_wr(11'h020, 16'h1234, 2'b00);
        ram_wr(11'h020, 16'hFF00, 2'b01);
        ram_rd("rd_ff34", 11'h020, 0);
        ram_wr(11'h020, 16'h5555, 2'b11);
        ram_rd("rd_ff34_keep", 11'h020, 0);

        // Swap
        ram_wr(11'h7FF, 16'hBEEF, 2'b00);
        ctrl_rd(1'b0);
        vblank();
        check("bank_swap", 32'(bank), 32'd1);
        rend("rend_beef", 11'h7FF);
        ram_rd("rd_other", 11'h7FF, 0);

        // No arm: bank holds; three reads arm a single swap
        vblank();
        vblank();
        ctrl_rd(1'b0); ctrl_rd(1'b0); ctrl_rd(1'b0);
        vblank();
        check("bank_once", 32'(bank), 32'd0);
        vblank();

        // Control register
        ctrl_wr(16'h0003, 2'b00);
        ctrl_rd(1'b0);
        vblank();
        ctrl_wr(16'h0000, 2'b10);
        ctrl_rd(1'b1);

        // Reset mid-access with a pending swap and bank=1
        if (m_bank == 0) begin
            ctrl_rd(1'b0);
            vblank();
        end
        ctrl_rd(1'b0);
        step();
        cpu_addr = pool[0]; rnw = 1'b1; dsn = 2'b00; ram_cs = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("mrst_ok", 32'(cpu_ok), 32'd0);
        check("mrst_bank", 32'(bank), 32'd0);
        check("mrst_mode", 32'(road_mode), 32'd0);
        ram_cs = 1'b0; rst = 1'b0;
        m_bank = 0; m_pend = 1'b0; m_mode = 2'd0;
        step();
        check("mrst_ok2", 32'(cpu_ok), 32'd0);
        vblank();

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            logic [10:0] a;
            a = pool[$urandom_range(0, 15)];
            case ($urandom_range(0, 6))
                0, 1: ram_wr(a, 16'($urandom), 2'($urandom));
                2:    ram_rd("rnd_rd", a, $urandom_range(0, 2));
                3:    ctrl_wr(16'($urandom), 2'($urandom));
                4:    ctrl_rd(1'($urandom));
                5:    vblank();
                default: rend("rnd_rend", a);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
